// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: instruction-fetch stage between the PC register and decode.
// Issues in-order instruction memory reads with a req/gnt handshake, keeps the
// PC and instruction for each read in a DEPTH-entry queue, and hands the queue
// head to decode with valid/ready. A redirect flushes the queue and counts the
// reads still in flight so that their responses are dropped when they return.
// Optional build macro FETCH_BYPASS_EN: forwards returning read data straight to
// decode when the entry being filled is the queue head (0-cycle rvalid->decode).
module ifu_fetch_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic [DATA_W-1:0] curr_pc_i,
    output logic [DATA_W-1:0] next_pc_o,
    output logic              imem_req_o,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [DATA_W-1:0] redirect_pc_i,
    output logic              id_valid_o,
    output logic [DATA_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    input  logic              id_ready_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // Discard count can exceed DEPTH when redirects stack up during discard.
    localparam int DW = AW + 4;

    logic [DATA_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     fill_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     occ_cnt;
    logic [CW-1:0]     pend_cnt;
    logic [DW-1:0]     discard_cnt;
    logic [DW-1:0]     redirect_discard;
    logic [DATA_W-1:0] last_pc;
    logic [DATA_W-1:0] last_inst;

    logic alloc;
    logic discarding;
    logic fill_en;
    logic head_filled;
    logic bypass;
    logic head_ready;
    logic release_en;

    assign discarding  = (discard_cnt != '0);
    assign alloc       = imem_req_o && imem_gnt_i;
    assign fill_en     = imem_rvalid_i && !discarding && (pend_cnt != '0);
    assign head_filled = filled_q[rd_ptr];

`ifdef FETCH_BYPASS_EN
    assign bypass = fill_en && (fill_ptr == rd_ptr) && !head_filled;
`else
    assign bypass = 1'b0;
`endif

    assign head_ready  = head_filled || bypass;
    assign id_valid_o  = head_ready && !redirect_i;
    assign release_en  = id_valid_o && id_ready_i;
    assign id_pc_o     = head_ready ? pc_q[rd_ptr] : last_pc;
    assign id_inst_o   = head_filled ? inst_q[rd_ptr] : (bypass ? imem_rdata_i : last_inst);

    assign imem_req_o  = rst_n && ena_i && !redirect_i && (occ_cnt < CW'(DEPTH));
    assign imem_addr_o = curr_pc_i & ~DATA_W'(3);

    // Next PC: redirect target wins, otherwise advance by one word on a grant.
    always_comb begin
        next_pc_o = curr_pc_i;
        if (rst_n && redirect_i) begin
            next_pc_o = redirect_pc_i & ~DATA_W'(3);
        end else if (alloc) begin
            next_pc_o = curr_pc_i + DATA_W'(4);
        end
    end

    // Reads left in flight after a redirect, minus one returning this cycle.
    always_comb begin
        redirect_discard = DW'(pend_cnt) + discard_cnt;
        if (imem_rvalid_i && (redirect_discard != '0)) begin
            redirect_discard = redirect_discard - DW'(1);
        end
    end

    // Queue state: allocate on grant, fill on rvalid, release on decode handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            filled_q    <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            occ_cnt     <= '0;
            pend_cnt    <= '0;
            discard_cnt <= '0;
        end else if (redirect_i) begin
            filled_q    <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            occ_cnt     <= '0;
            pend_cnt    <= '0;
            discard_cnt <= redirect_discard;
        end else begin
            if (alloc) begin
                pc_q[wr_ptr]     <= curr_pc_i;
                filled_q[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (imem_rvalid_i && discarding) begin
                discard_cnt <= discard_cnt - DW'(1);
            end
            if (fill_en) begin
                inst_q[fill_ptr]   <= imem_rdata_i;
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + AW'(1);
            end
            if (release_en) begin
                filled_q[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + AW'(1);
            end
            occ_cnt  <= occ_cnt + CW'(alloc) - CW'(release_en);
            pend_cnt <= pend_cnt + CW'(alloc) - CW'(fill_en);
        end
    end

    // Remember the last presented instruction so outputs hold while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc   <= '0;
            last_inst <= '0;
        end else if (head_ready) begin
            last_pc   <= id_pc_o;
            last_inst <= id_inst_o;
        end
    end

`ifndef SYNTHESIS
    // A response must always belong to an outstanding or discarded read.
    rvalid_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid_i |-> ((pend_cnt != '0) || discarding));
`endif

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// tb_ifu_fetch_buf: directed bench for ifu_fetch_buf with a PC register model,
// an in-order instruction memory model and a delivery scoreboard.
module tb_ifu_fetch_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena_i;
    logic [31:0] curr_pc_i;
    logic [31:0] next_pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    logic [31:0] mem_q[$];
    bit          mem_hold = 1'b0;

    ifu_fetch_buf #(.DATA_W(32), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena_i         (ena_i),
        .curr_pc_i     (curr_pc_i),
        .next_pc_o     (next_pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_ready_i    (id_ready_i)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory contents: instruction word stored at each address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input bit ena, input bit gnt, input bit rdy,
                                 input bit redir, input logic [31:0] rpc);
        ena_i         = ena;
        imem_gnt_i    = gnt;
        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = inst_of(pc);
        sb.push_back(e);
    endtask

    // Present the oldest outstanding read unless the memory is stalled.
    task automatic mem_drive();
        if (!mem_hold && mem_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = inst_of(mem_q[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    endtask

    // Advance one clock: sample handshakes mid-cycle, then update PC register and memory.
    task automatic next_cycle();
        logic        granted;
        logic        consumed;
        logic [31:0] npc;
        logic [31:0] addr;
        @(negedge clk);
        granted  = imem_req_o && imem_gnt_i;
        consumed = imem_rvalid_i;
        npc      = next_pc_o;
        addr     = imem_addr_o;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_q.delete();
            curr_pc_i = '0;
        end else begin
            if (consumed && mem_q.size() > 0) void'(mem_q.pop_front());
            if (granted) mem_q.push_back(addr);
            curr_pc_i = npc;
        end
        mem_drive();
    endtask

    // Monitor: every decode handshake must match the next scoreboard entry.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && id_valid_o && id_ready_i) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_delivery_pc", id_pc_o, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("deliver_pc", id_pc_o, e.pc);
                    checkOutput("deliver_inst", id_inst_o, e.inst);
                end
            end
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1, 1, 0, 0, 32'h0);
        curr_pc_i = 32'h44;
        mem_drive();
        fork
            monitor_loop();
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_id_valid", 32'(id_valid_o), 32'h0);
        checkOutput("rst_imem_req", 32'(imem_req_o), 32'h0);
        checkOutput("rst_next_pc", next_pc_o, 32'h44);
        checkOutput("rst_id_pc", id_pc_o, 32'h0);
        checkOutput("rst_id_inst", id_inst_o, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        // Test 1: streaming fetch from PC 0.
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i < 4, 1, 1, 0, 32'h0);
            #1;
            if (i < 4) begin
                checkOutput("t1_addr", imem_addr_o, 32'(4 * i));
                checkOutput("t1_next_pc", next_pc_o, 32'(4 * i + 4));
            end
            if (i >= 2 && i < 6) begin
                checkOutput("t1_id_valid", 32'(id_valid_o), 32'h1);
                checkOutput("t1_id_pc", id_pc_o, 32'(4 * (i - 2)));
            end
            if (i == 6) begin
                checkOutput("t1_empty_valid", 32'(id_valid_o), 32'h0);
                checkOutput("t1_empty_hold_pc", id_pc_o, 32'hC);
                checkOutput("t1_empty_hold_inst", id_inst_o, inst_of(32'hC));
            end
            next_cycle();
        end
        checkOutput("t1_sb_empty", 32'(sb.size()), 32'h0);

        // Test 2: decode stalled until the queue is full, then drains.
        expect_pc(32'h10); expect_pc(32'h14); expect_pc(32'h18);
        expect_pc(32'h1C); expect_pc(32'h20);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i < 8, 1, i >= 6, 0, 32'h0);
            #1;
            if (i < 4) checkOutput("t2_addr", imem_addr_o, 32'(32'h10 + 4 * i));
            if (i == 4 || i == 5) begin
                checkOutput("t2_full_req", 32'(imem_req_o), 32'h0);
                checkOutput("t2_full_next_pc", next_pc_o, 32'h20);
                checkOutput("t2_stall_valid", 32'(id_valid_o), 32'h1);
                checkOutput("t2_stall_pc", id_pc_o, 32'h10);
            end
            if (i == 6) checkOutput("t2_release_req", 32'(imem_req_o), 32'h0);
            if (i == 7) begin
                checkOutput("t2_resume_req", 32'(imem_req_o), 32'h1);
                checkOutput("t2_resume_addr", imem_addr_o, 32'h20);
            end
            next_cycle();
        end
        checkOutput("t2_sb_empty", 32'(sb.size()), 32'h0);

        // Test 3: redirect with two reads in flight.
        mem_hold = 1'b1;
        mem_drive();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 1, 0, 32'h0);
            #1;
            checkOutput("t3_addr", imem_addr_o, 32'(32'h24 + 4 * i));
            next_cycle();
        end
        applyStimulus(1, 1, 1, 1, 32'h103);
        #1;
        checkOutput("t3_redirect_next_pc", next_pc_o, 32'h100);
        checkOutput("t3_redirect_req", 32'(imem_req_o), 32'h0);
        next_cycle();
        mem_hold = 1'b0;
        mem_drive();
        expect_pc(32'h100);
        for (int i = 3; i < 8; i++) begin
            applyStimulus(i == 3, 1, 1, 0, 32'h0);
            #1;
            if (i == 3) checkOutput("t3_new_addr", imem_addr_o, 32'h100);
            if (i < 6) checkOutput("t3_drop_valid", 32'(id_valid_o), 32'h0);
            next_cycle();
        end
        checkOutput("t3_sb_empty", 32'(sb.size()), 32'h0);

        // Test 4: redirect in the same cycle as one response, three outstanding.
        mem_hold = 1'b1;
        mem_drive();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 0, 32'h0);
            #1;
            checkOutput("t4_addr", imem_addr_o, 32'(32'h104 + 4 * i));
            next_cycle();
        end
        mem_hold = 1'b0;
        mem_drive();
        applyStimulus(1, 1, 1, 1, 32'h100);
        #1;
        checkOutput("t4_redirect_next_pc", next_pc_o, 32'h100);
        checkOutput("t4_redirect_req", 32'(imem_req_o), 32'h0);
        next_cycle();
        expect_pc(32'h100);
        for (int i = 4; i < 9; i++) begin
            applyStimulus(i == 4, 1, 1, 0, 32'h0);
            #1;
            if (i == 4) begin
                checkOutput("t4_new_addr", imem_addr_o, 32'h100);
                checkOutput("t4_new_next_pc", next_pc_o, 32'h104);
            end
            if (i < 7) checkOutput("t4_drop_valid", 32'(id_valid_o), 32'h0);
            next_cycle();
        end
        checkOutput("t4_sb_empty", 32'(sb.size()), 32'h0);

        // Test 5: PC wrap at the top of the address space, hold without grant.
        applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFE);
        #1;
        checkOutput("t5_redirect_next_pc", next_pc_o, 32'hFFFF_FFFC);
        next_cycle();
        expect_pc(32'hFFFF_FFFC);
        applyStimulus(1, 1, 1, 0, 32'h0);
        #1;
        checkOutput("t5_wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        checkOutput("t5_wrap_next_pc", next_pc_o, 32'h0);
        next_cycle();
        applyStimulus(1, 0, 1, 0, 32'h0);
        #1;
        checkOutput("t5_nognt_req", 32'(imem_req_o), 32'h1);
        checkOutput("t5_nognt_next_pc", next_pc_o, 32'h0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 32'h0);
            next_cycle();
        end
        checkOutput("t5_sb_empty", 32'(sb.size()), 32'h0);

        // Test 6: asynchronous reset with two filled entries queued.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i < 2, 1, 0, 0, 32'h0);
            next_cycle();
        end
        applyStimulus(1, 0, 0, 0, 32'h0);
        #1;
        checkOutput("t6_pre_valid", 32'(id_valid_o), 32'h1);
        checkOutput("t6_pre_req", 32'(imem_req_o), 32'h1);
        checkOutput("t6_pre_inst", id_inst_o, inst_of(32'h0));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(id_valid_o), 32'h0);
        checkOutput("t6_rst_req", 32'(imem_req_o), 32'h0);
        checkOutput("t6_rst_inst", id_inst_o, 32'h0);
        mem_q.delete();
        mem_drive();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 2, 1, 1, 0, 32'h0);
            #1;
            if (i < 2) checkOutput("t6_restart_addr", imem_addr_o, 32'(4 * i));
            if (i == 0) checkOutput("t6_restart_next_pc", next_pc_o, 32'h4);
            next_cycle();
        end
        checkOutput("t6_sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
